comparator_4_serial: RTL
========================

COMPARATOR_4_SERIAL -- requirements
Module: comparator_4_serial

Interface
REQ-001 Parameter: N, default 4, operand width in bits (unsigned); legal range 2..16.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port: bit_valid  input  1  a_bit/b_bit carry one operand bit pair this cycle.
REQ-005 Port: bit_ready  output  1  block accepts a bit pair this cycle.
REQ-006 Port: a_bit  input  1  serial bit of operand A, LSB first.
REQ-007 Port: b_bit  input  1  serial bit of operand B, LSB first.
REQ-008 Port: res_valid  output  1  Eq/Gt/St hold a completed comparison.
REQ-009 Port: res_ready  input  1  consumer accepts the result.
REQ-010 Port: Eq  output  1  A == B (valid only while res_valid=1).
REQ-011 Port: Gt  output  1  A > B (valid only while res_valid=1).
REQ-012 Port: St  output  1  A < B (valid only while res_valid=1).
REQ-013 Port: bit_cnt  output  clog2(N+1)  number of bit pairs accepted in the current operation.

Function
REQ-014 A bit pair SHALL be accepted only in a cycle where bit_valid=1 and bit_ready=1 (transfer).
REQ-015 FSM states SHALL be IDLE, SHIFT, DONE; bit_ready=1 in IDLE and SHIFT, 0 in DONE.
REQ-016 IDLE: on transfer -> SHIFT with bit_cnt=1; otherwise stay in IDLE with bit_cnt=0.
REQ-017 SHIFT: each transfer increments bit_cnt; the transfer that makes bit_cnt=N -> DONE.
REQ-018 SHIFT with bit_valid=0 SHALL hold all state (gaps of any length allowed, no timeout).
REQ-019 Running relation (EQ/GT/LT) SHALL start at EQ on the first transfer of an operation and update per transfer: a_bit=1,b_bit=0 -> GT; a_bit=0,b_bit=1 -> LT; equal bits -> unchanged.
REQ-020 Because bits arrive LSB first, a later (more significant) differing bit SHALL override any earlier relation.
REQ-021 In DONE, res_valid=1 and exactly one of Eq/Gt/St SHALL be 1, equal to the final relation.
REQ-022 Latency: res_valid SHALL rise in the cycle after the N-th transfer edge, i.e. registered, no combinational path from a_bit/b_bit to Eq/Gt/St.
REQ-023 DONE: res_valid and Eq/Gt/St SHALL hold stable until res_valid=1 and res_ready=1 on a clock edge; then -> IDLE, res_valid=0, bit_cnt=0.
REQ-024 No bit pair SHALL be accepted in the cycle the result is consumed (bit_ready=0 in DONE); the next operation starts in IDLE.
REQ-025 res_ready asserted while res_valid=0 SHALL have no effect.
REQ-026 Outside DONE, Eq, Gt, St SHALL all be 0.
REQ-027 a_bit/b_bit SHALL be ignored in cycles without a transfer.

Reset
REQ-028 rst=1 at a rising edge SHALL force IDLE, bit_cnt=0, relation=EQ, res_valid=0, Eq=Gt=St=0; bit_ready=1 from the following cycle.
REQ-029 rst SHALL override every other input in the same cycle, including a transfer or a result handshake.
REQ-030 rst asserted mid-operation (SHIFT) or with an unconsumed result (DONE) SHALL discard the partial/pending comparison; no result is ever produced for it.

Verification
REQ-031 N=4, A=0101, B=0101 sent LSB first on 4 consecutive cycles, res_ready=1 -> one cycle later res_valid=1, Eq=1, Gt=0, St=0; next cycle back in IDLE.
REQ-032 A=1000, B=0111 (LSB difference first, MSB decides) -> Gt=1; A=0001, B=0000 -> Gt=1; A=0000, B=1111 -> St=1.
REQ-033 A=1010, B=0110 with bit_valid low for 3 cycles between bits 2 and 3 -> bit_cnt holds during gaps, result St=0, Gt=1.
REQ-034 Result pending with res_ready=0 for 5 cycles while bit_valid=1 -> bit_ready=0, bit_cnt stays 4, Eq/Gt/St stable; first bit of next operation accepted only after the handshake cycle.
REQ-035 rst pulsed after 2 transfers, then A=0011,B=0011 sent -> single result Eq=1, no stale relation from the aborted operation.
REQ-036 Exhaustive: all 256 (A,B) pairs with random bit_valid/res_ready gaps -> Eq/Gt/St match A==B, A>B, A<B for every pair.

Source files
------------

// File: rtl/comparator_4_serial.sv
// ---------------------------------------------------------------------------
// comparator_4_serial
//
// Purpose:
//   Bit-serial unsigned magnitude comparator. Two N-bit operands arrive one
//   bit pair per transfer, least significant bit first. A running relation
//   is updated on every transfer. Because each later bit is more significant,
//   any differing bit overrides whatever relation was recorded before it.
//   Once N bit pairs have been accepted, the final relation is presented as
//   a registered result that is held until the consumer takes it.
//
// Ports:
//   clk        in   single clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset, wins over every input
//   bit_valid  in   a_bit/b_bit carry a bit pair this cycle
//   bit_ready  out  block accepts a bit pair this cycle (low while DONE)
//   a_bit      in   serial bit of operand A, LSB first
//   b_bit      in   serial bit of operand B, LSB first
//   res_valid  out  Eq/Gt/St hold a completed comparison
//   res_ready  in   consumer accepts the result
//   Eq         out  A == B (only meaningful while res_valid=1, else 0)
//   Gt         out  A >  B (only meaningful while res_valid=1, else 0)
//   St         out  A <  B (only meaningful while res_valid=1, else 0)
//   bit_cnt    out  number of bit pairs accepted in the current operation
// ---------------------------------------------------------------------------
module comparator_4_serial #(
  parameter int N = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bit_valid,
  output logic                   bit_ready,
  input  logic                   a_bit,
  input  logic                   b_bit,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   Eq,
  output logic                   Gt,
  output logic                   St,
  output logic [$clog2(N+1)-1:0] bit_cnt
);

  localparam int CW = $clog2(N+1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REL_EQ = 2'd0,
    REL_GT = 2'd1,
    REL_LT = 2'd2
  } rel_t;

  state_t          r_state;
  state_t          w_stateNext;
  rel_t            r_rel;
  rel_t            w_relNext;
  rel_t            w_relUpdated;
  logic [CW-1:0]   r_bitCnt;
  logic [CW-1:0]   w_bitCntNext;
  logic            w_transfer;

  // A transfer only happens when the producer offers a pair and we are not
  // sitting on an unconsumed result.
  assign bit_ready  = (r_state != DONE);
  assign w_transfer = bit_valid && bit_ready;

  // Relation after folding in the current bit pair. The first transfer of an
  // operation starts from EQ, so a stale relation can never leak in from the
  // previous operation. Equal bits keep the base; a differing bit overrides
  // it because it is more significant than everything seen so far.
  always_comb begin
    rel_t w_base;
    w_base = (r_state == IDLE) ? REL_EQ : r_rel;
    w_relUpdated = w_base;
    if (a_bit != b_bit) begin
      w_relUpdated = a_bit ? REL_GT : REL_LT;
    end
  end

  // Next-state logic. Everything holds unless a transfer or a result
  // handshake occurs, so gaps in bit_valid and early res_ready are harmless.
  always_comb begin
    w_stateNext  = r_state;
    w_relNext    = r_rel;
    w_bitCntNext = r_bitCnt;
    case (r_state)
      IDLE: begin
        if (w_transfer) begin
          w_stateNext  = SHIFT;
          w_relNext    = w_relUpdated;
          w_bitCntNext = CW'(1);
        end
      end
      SHIFT: begin
        if (w_transfer) begin
          w_relNext    = w_relUpdated;
          w_bitCntNext = r_bitCnt + CW'(1);
          if (r_bitCnt == CW'(N-1)) begin
            w_stateNext = DONE;
          end
        end
      end
      DONE: begin
        if (res_ready) begin
          w_stateNext  = IDLE;
          w_relNext    = REL_EQ;
          w_bitCntNext = '0;
        end
      end
      default: begin
        w_stateNext  = IDLE;
        w_relNext    = REL_EQ;
        w_bitCntNext = '0;
      end
    endcase
  end

  // State registers. Reset is synchronous and overrides any transfer or
  // handshake arriving in the same cycle, discarding partial work.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rel    <= REL_EQ;
      r_bitCnt <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_rel    <= w_relNext;
      r_bitCnt <= w_bitCntNext;
    end
  end

  // Result outputs come purely from registered state, so there is no
  // combinational path from the serial inputs to Eq/Gt/St.
  always_comb begin
    res_valid = (r_state == DONE);
    Eq        = res_valid && (r_rel == REL_EQ);
    Gt        = res_valid && (r_rel == REL_GT);
    St        = res_valid && (r_rel == REL_LT);
  end

  assign bit_cnt = r_bitCnt;

endmodule
